// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the
// multiply latency default, the EX/MEM register layout and the operand
// forwarding selector (used only when EX_FORWARD_EN is defined).
package execute_stage_pkg;

  localparam int unsigned MUL_LATENCY_DEFAULT = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  typedef enum logic {ST_IDLE, ST_BUSY} mul_state_e;

  // Everything EX/MEM carries besides the ALU result itself.
  typedef struct packed {
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        wr_reg_en;
    logic        wr_mem_en;
    logic        rd_mem_en;
    logic        wb_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    ctrl_t       ctrl;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = '0;

  // EX/MEM match beats MEM/WB match; register 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] id_val,
    input logic        em_en,
    input logic [4:0]  em_reg,
    input logic [31:0] em_val,
    input logic        wb_en,
    input logic [4:0]  wb_reg,
    input logic [31:0] wb_val
  );
    if (em_en && (em_reg != 5'd0) && (em_reg == src)) return em_val;
    if (wb_en && (wb_reg != 5'd0) && (wb_reg == src)) return wb_val;
    return id_val;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Single-cycle combinational ALU for the execute stage. Multiply is not
// handled here; its code (and any undefined code) yields 0.
module alu
  import execute_stage_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_result
);

  // Select the result for the requested operation.
  always_comb begin
    // NOTE: default first so every path assigns o_result and no latch is inferred.
    o_result = '0;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
      ALU_NOR: o_result = ~(i_a | i_b);
      // Shift the second operand (rt when AluSrc=0) by the shamt field.
      ALU_SLL: o_result = i_b << i_shamt;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand selection (optionally forwarded), single-cycle ALU
// and a multi-cycle multiply FSM feeding the EX/MEM pipeline register.
// Optional feature: define EX_FORWARD_EN to enable EX/MEM and MEM/WB
// operand forwarding; without it the register file values are used as-is.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IDIExreadData1,
  input  logic [31:0] IDIExreadData2,
  input  logic [31:0] IDExImmediateFieldSignextended,
  input  logic [4:0]  IDExRs,
  input  logic [4:0]  IDExRt,
  input  logic [4:0]  IDExRd,
  input  logic        IDExAluSrc,
  input  logic        IDExReg_dst,
  input  logic        IDExWriteRegEnable,
  input  logic        IDExWriteMemoryEnable,
  input  logic        IDExReadMemoryEnable,
  input  logic        IDExwritebackRegCtrl,
  input  logic [3:0]  IDExAluOp,
  input  logic        ExFlush,
  input  logic [4:0]  MemWBwritereg,
  input  logic        MemWBWriteRegEnable,
  input  logic [31:0] writeData,
  output logic        ExStall,
  output logic [31:0] ExMemAluResult,
  output logic [31:0] ExMemWriteData,
  output logic [4:0]  ExMemWriteReg,
  output logic        ExMemZero,
  output logic        ExMemWriteRegEnable,
  output logic        ExMemWriteMemoryEnable,
  output logic        ExMemReadMemoryEnable,
  output logic        ExMemwritebackRegCtrl
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 2);

  exmem_t      r_exmem;
  ctrl_t       w_ctrl;
  ctrl_t       r_mul_ctrl;
  mul_state_e  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic [31:0] w_mul_result;
  logic        w_is_mul;

`ifdef EX_FORWARD_EN
  assign w_rs_val = fwd_sel(IDExRs, IDIExreadData1,
                            r_exmem.ctrl.wr_reg_en, r_exmem.ctrl.write_reg, r_exmem.result,
                            MemWBWriteRegEnable, MemWBwritereg, writeData);
  assign w_rt_val = fwd_sel(IDExRt, IDIExreadData2,
                            r_exmem.ctrl.wr_reg_en, r_exmem.ctrl.write_reg, r_exmem.result,
                            MemWBWriteRegEnable, MemWBwritereg, writeData);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{IDExRs, MemWBwritereg, MemWBWriteRegEnable, writeData};
  assign w_rs_val     = IDIExreadData1;
  assign w_rt_val     = IDIExreadData2;
`endif

  assign w_op_b   = IDExAluSrc ? IDExImmediateFieldSignextended : w_rt_val;
  assign w_is_mul = (IDExAluOp == ALU_MUL);

  assign w_ctrl = '{write_data: w_rt_val,
                    write_reg:  IDExReg_dst ? IDExRd : IDExRt,
                    wr_reg_en:  IDExWriteRegEnable,
                    wr_mem_en:  IDExWriteMemoryEnable,
                    rd_mem_en:  IDExReadMemoryEnable,
                    wb_ctrl:    IDExwritebackRegCtrl};

  alu u_alu (
    .i_op     (IDExAluOp),
    .i_a      (w_rs_val),
    .i_b      (w_op_b),
    .i_shamt  (IDExImmediateFieldSignextended[10:6]),
    .o_result (w_alu_result)
  );

  // Product of the operands captured at multiply start, never the live ones.
  assign w_mul_result = r_mul_a * r_mul_b;

  // Stall covers the starting cycle and every BUSY cycle but the last.
  assign ExStall = rst_n && (((r_state == ST_IDLE) && w_is_mul && !ExFlush) ||
                             ((r_state == ST_BUSY) && (r_count != 4'd0)));

  // Multiply FSM and EX/MEM register; a bubble is loaded unless a result retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_exmem    <= EXMEM_BUBBLE;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_ctrl <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      r_exmem <= EXMEM_BUBBLE;
      case (r_state)
        ST_IDLE: begin
          if (!ExFlush) begin
            if (w_is_mul) begin
              r_state    <= ST_BUSY;
              r_count    <= CNT_INIT;
              r_mul_a    <= w_rs_val;
              r_mul_b    <= w_op_b;
              r_mul_ctrl <= w_ctrl;
            end else begin
              r_exmem <= '{result: w_alu_result,
                           zero:   (w_alu_result == 32'd0),
                           ctrl:   w_ctrl};
            end
          end
        end
        ST_BUSY: begin
          if (ExFlush) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_state <= ST_IDLE;
            r_exmem <= '{result: w_mul_result,
                         zero:   (w_mul_result == 32'd0),
                         ctrl:   r_mul_ctrl};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign ExMemAluResult         = r_exmem.result;
  assign ExMemZero              = r_exmem.zero;
  assign ExMemWriteData         = r_exmem.ctrl.write_data;
  assign ExMemWriteReg          = r_exmem.ctrl.write_reg;
  assign ExMemWriteRegEnable    = r_exmem.ctrl.wr_reg_en;
  assign ExMemWriteMemoryEnable = r_exmem.ctrl.wr_mem_en;
  assign ExMemReadMemoryEnable  = r_exmem.ctrl.rd_mem_en;
  assign ExMemwritebackRegCtrl  = r_exmem.ctrl.wb_ctrl;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (multiply tracked by its completion edge number).
module tb_execute_stage;

  localparam int MUL_LAT = 4;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_SLL = 4'b1000, OP_MUL = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IDIExreadData1, IDIExreadData2, IDExImmediateFieldSignextended;
  logic [4:0]  IDExRs, IDExRt, IDExRd;
  logic        IDExAluSrc, IDExReg_dst, IDExWriteRegEnable, IDExWriteMemoryEnable;
  logic        IDExReadMemoryEnable, IDExwritebackRegCtrl;
  logic [3:0]  IDExAluOp;
  logic        ExFlush;
  logic [4:0]  MemWBwritereg;
  logic        MemWBWriteRegEnable;
  logic [31:0] writeData;
  logic        ExStall;
  logic [31:0] ExMemAluResult, ExMemWriteData;
  logic [4:0]  ExMemWriteReg;
  logic        ExMemZero, ExMemWriteRegEnable, ExMemWriteMemoryEnable;
  logic        ExMemReadMemoryEnable, ExMemwritebackRegCtrl;

  execute_stage #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDIExreadData1(IDIExreadData1), .IDIExreadData2(IDIExreadData2),
    .IDExImmediateFieldSignextended(IDExImmediateFieldSignextended),
    .IDExRs(IDExRs), .IDExRt(IDExRt), .IDExRd(IDExRd),
    .IDExAluSrc(IDExAluSrc), .IDExReg_dst(IDExReg_dst),
    .IDExWriteRegEnable(IDExWriteRegEnable), .IDExWriteMemoryEnable(IDExWriteMemoryEnable),
    .IDExReadMemoryEnable(IDExReadMemoryEnable), .IDExwritebackRegCtrl(IDExwritebackRegCtrl),
    .IDExAluOp(IDExAluOp), .ExFlush(ExFlush),
    .MemWBwritereg(MemWBwritereg), .MemWBWriteRegEnable(MemWBWriteRegEnable),
    .writeData(writeData), .ExStall(ExStall),
    .ExMemAluResult(ExMemAluResult), .ExMemWriteData(ExMemWriteData),
    .ExMemWriteReg(ExMemWriteReg), .ExMemZero(ExMemZero),
    .ExMemWriteRegEnable(ExMemWriteRegEnable), .ExMemWriteMemoryEnable(ExMemWriteMemoryEnable),
    .ExMemReadMemoryEnable(ExMemReadMemoryEnable), .ExMemwritebackRegCtrl(ExMemwritebackRegCtrl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        z, rwe, mwe, mre, wbc;
  } m_out_t;

  m_out_t      m_q = '0;
  m_out_t      m_hold;
  bit          m_busy = 0;
  bit          m_last_stall = 0;
  int          m_edge = 0;
  int          m_done_edge = 0;
  logic [31:0] m_mul_a, m_mul_b;

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] idv);
    if (FWD && m_q.rwe && r != 0 && m_q.wr == r) return m_q.res;
    if (FWD && MemWBWriteRegEnable && r != 0 && MemWBwritereg == r) return writeData;
    return idv;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return b << sh;
      default: return 32'd0;
    endcase
  endfunction

  // Stall while a multiply is being accepted or its completion edge is not next.
  function automatic bit m_stall();
    if (!rst_n) return 1'b0;
    return (!m_busy && IDExAluOp == OP_MUL && !ExFlush) ||
           (m_busy && (m_edge + 1) < m_done_edge);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0;
      m_busy = 0;
      m_last_stall = 0;
    end else begin
      logic [31:0] a, rt_v, b, r;
      m_out_t nxt;
      m_last_stall = m_stall();
      m_edge++;
      a    = m_fwd(IDExRs, IDIExreadData1);
      rt_v = m_fwd(IDExRt, IDIExreadData2);
      b    = IDExAluSrc ? IDExImmediateFieldSignextended : rt_v;
      nxt  = '0;
      if (!m_busy) begin
        if (!ExFlush) begin
          if (IDExAluOp == OP_MUL) begin
            m_busy = 1;
            m_done_edge = m_edge + MUL_LAT - 1;
            m_mul_a = a;
            m_mul_b = b;
            m_hold = '{res: 0, wd: rt_v, wr: IDExReg_dst ? IDExRd : IDExRt, z: 0,
                       rwe: IDExWriteRegEnable, mwe: IDExWriteMemoryEnable,
                       mre: IDExReadMemoryEnable, wbc: IDExwritebackRegCtrl};
          end else begin
            r = m_alu(IDExAluOp, a, b, IDExImmediateFieldSignextended[10:6]);
            nxt = '{res: r, wd: rt_v, wr: IDExReg_dst ? IDExRd : IDExRt, z: (r == 0),
                    rwe: IDExWriteRegEnable, mwe: IDExWriteMemoryEnable,
                    mre: IDExReadMemoryEnable, wbc: IDExwritebackRegCtrl};
          end
        end
      end else if (ExFlush) begin
        m_busy = 0;
      end else if (m_edge == m_done_edge) begin
        m_busy = 0;
        nxt = m_hold;
        nxt.res = m_mul_a * m_mul_b;
        nxt.z = (nxt.res == 0);
      end
      m_q = nxt;
    end
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    check("exmem", {ExMemAluResult, ExMemWriteData, ExMemWriteReg, ExMemZero,
                    ExMemWriteRegEnable, ExMemWriteMemoryEnable,
                    ExMemReadMemoryEnable, ExMemwritebackRegCtrl}, m_q);
    check("stall", ExStall, m_stall());
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic alusrc, input logic regdst,
                        input logic wre);
    IDExAluOp = op;
    IDIExreadData1 = d1;
    IDIExreadData2 = d2;
    IDExImmediateFieldSignextended = imm;
    IDExRs = rs;
    IDExRt = rt;
    IDExRd = rd;
    IDExAluSrc = alusrc;
    IDExReg_dst = regdst;
    IDExWriteRegEnable = wre;
    IDExWriteMemoryEnable = 1'b0;
    IDExReadMemoryEnable = 1'b0;
    IDExwritebackRegCtrl = wre;
  endtask

  function automatic logic [31:0] rand_data();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
  endfunction

  initial begin
    int st;
    logic [3:0] ops [10];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL, OP_MUL, OP_MUL, 4'b0011};

    rst_n = 1'b0;
    ExFlush = 1'b0;
    MemWBwritereg = '0;
    MemWBWriteRegEnable = 1'b0;
    writeData = '0;
    set_op(OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_outputs", {ExMemAluResult, ExMemWriteRegEnable, ExStall}, 0);
    rst_n = 1'b1;

    // ADD 7 + 0xFFFFFFFF wraps to 6.
    set_op(OP_ADD, 32'd7, 32'hFFFF_FFFF, 0, 5'd1, 5'd2, 5'd3, 0, 1, 1);
    tick();
    check("add_wrap_result", ExMemAluResult, 32'd6);
    check("add_wrap_zero", ExMemZero, 1'b0);
    check("add_wrap_wreg", ExMemWriteReg, 5'd3);

    // ADD writing r5, then SUB reading r5.
    set_op(OP_ADD, 32'd10, 32'd20, 0, 5'd1, 5'd2, 5'd5, 0, 1, 1);
    tick();
    check("fwd_producer", ExMemAluResult, 32'd30);
    set_op(OP_SUB, 32'd999, 32'd4, 0, 5'd5, 5'd6, 5'd7, 0, 1, 1);
    tick();
    check("fwd_consumer", ExMemAluResult, FWD ? 32'd26 : 32'd995);

    // r0 is never forwarded: SLT -1 < 1 gives 1.
    set_op(OP_ADD, 32'd100, 32'd0, 0, 5'd1, 5'd2, 5'd0, 0, 1, 1);
    MemWBwritereg = 5'd0;
    MemWBWriteRegEnable = 1'b1;
    writeData = 32'd55;
    tick();
    check("r0_producer", {ExMemAluResult, ExMemWriteReg}, {32'd100, 5'd0});
    set_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 5'd0, 5'd1, 5'd4, 0, 1, 1);
    tick();
    check("slt_no_r0_fwd", ExMemAluResult, 32'd1);
    MemWBWriteRegEnable = 1'b0;

    // MUL 3*5: three stall cycles, bubbles, result on the 4th edge.
    set_op(OP_MUL, 32'd3, 32'd5, 0, 5'd8, 5'd9, 5'd10, 0, 1, 1);
    #1;
    st = 0;
    for (int e = 1; e <= 4; e++) begin
      if (ExStall) st++;
      tick();
      if (e < 4) check("mul_bubble", {ExMemAluResult, ExMemWriteRegEnable}, 0);
    end
    check("mul_stall_cycles", st, 3);
    check("mul_result", {ExMemAluResult, ExMemWriteReg, ExMemWriteRegEnable}, {32'd15, 5'd10, 1'b1});

    // Flush on the 2nd BUSY cycle aborts the multiply.
    set_op(OP_MUL, 32'd6, 32'd7, 0, 5'd8, 5'd9, 5'd10, 0, 1, 1);
    tick();
    tick();
    ExFlush = 1'b1;
    #1;
    check("flush_busy_stall", ExStall, 1'b1);
    tick();
    ExFlush = 1'b0;
    set_op(OP_AND, 32'd12, 32'd10, 0, 5'd1, 5'd2, 5'd3, 0, 1, 1);
    #1;
    check("flush_after_stall", ExStall, 1'b0);
    check("flush_bubble", {ExMemAluResult, ExMemWriteRegEnable}, 0);
    tick();
    check("flush_next_op", ExMemAluResult, 32'd8);

    // Reset in the middle of a multiply.
    set_op(OP_MUL, 32'd9, 32'd9, 0, 5'd8, 5'd9, 5'd10, 0, 1, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_mul", {ExMemAluResult, ExMemWriteRegEnable, ExStall}, 0);
    tick();
    rst_n = 1'b1;
    set_op(OP_ADD, 32'd4, 32'd5, 0, 5'd1, 5'd2, 5'd3, 0, 1, 1);
    #1;
    check("post_reset_stall", ExStall, 1'b0);
    tick();
    check("post_reset_add", ExMemAluResult, 32'd9);

    // Randomized traffic; ID/EX held while the previous cycle stalled.
    for (int i = 0; i < 600; i++) begin
      if (!(m_last_stall && !ExFlush)) begin
        set_op(ops[$urandom_range(0, 9)], rand_data(), rand_data(), rand_data(),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        IDExWriteMemoryEnable = 1'($urandom_range(0, 1));
        IDExReadMemoryEnable = 1'($urandom_range(0, 1));
      end
      ExFlush = ($urandom_range(0, 11) == 0);
      MemWBwritereg = 5'($urandom_range(0, 7));
      MemWBWriteRegEnable = 1'($urandom_range(0, 1));
      writeData = rand_data();
      tick();
    end

    ExFlush = 1'b0;
    set_op(OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter MUL_LATENCY, default 4, is the total multiply cycles (legal 2..15).
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 IDIExreadData1 / IDIExreadData2  in  32 each  register operands from ID/EX.
REQ-005 IDExImmediateFieldSignextended  in  32  immediate; [10:6] is shamt.
REQ-006 IDExRs / IDExRt / IDExRd  in  5 each  register numbers.
REQ-007 IDExAluSrc, IDExReg_dst, IDExWriteRegEnable, IDExWriteMemoryEnable, IDExReadMemoryEnable, IDExwritebackRegCtrl  in  1 each  control from ID/EX.
REQ-008 IDExAluOp  in  4  ALU operation.
REQ-009 ExFlush  in  1  squash the current EX instruction.
REQ-010 MemWBwritereg  in  5; MemWBWriteRegEnable  in  1; writeData  in  32  WB forwarding source.
REQ-011 ExStall  out  1  high while a multiply occupies EX; upstream holds ID/EX.
REQ-012 ExMemAluResult  out 32; ExMemWriteData  out 32; ExMemWriteReg  out 5; ExMemZero  out 1; ExMemWriteRegEnable, ExMemWriteMemoryEnable, ExMemReadMemoryEnable, ExMemwritebackRegCtrl  out 1 each  EX/MEM register.

Function
REQ-013 AluOp codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 SLL by shamt, 1001 MUL; other codes give result 0.
REQ-014 Operand A = forwarded Rs value; operand B = IDExAluSrc ? immediate : forwarded Rt value; ExMemWriteData = forwarded Rt value.
REQ-015 ADD/SUB wrap modulo 2^32, no overflow trap; MUL yields the low 32 bits of the product.
REQ-016 ExMemWriteReg = IDExReg_dst ? IDExRd : IDExRt; ExMemZero = (result == 0).
REQ-017 Forwarding per operand: EX/MEM match (ExMemWriteRegEnable, ExMemWriteReg != 0, equal register) wins over MEM/WB match (same rules); otherwise the ID/EX value; register 0 is never forwarded.
REQ-018 Non-MUL ops: single-cycle; EX/MEM loads result and controls on the next posedge.
REQ-019 Multiply FSM states IDLE and BUSY; IDLE with MUL and no flush -> BUSY, operands captured, count = MUL_LATENCY-2.
REQ-020 In BUSY, count decrements each cycle; at count 0 the result and controls load into EX/MEM and the FSM returns to IDLE.
REQ-021 ExStall = (IDLE and MUL and not ExFlush) or (BUSY and count != 0); it is high for exactly MUL_LATENCY-1 cycles.
REQ-022 While ExStall is high, EX/MEM loads a bubble (all four enables 0, data 0).
REQ-023 ExFlush loads a bubble; flush with MUL in IDLE does not start the multiply; flush in BUSY aborts to IDLE.
REQ-024 Captured multiply operands do not change during BUSY even when forwarding sources change.

Reset
REQ-025 rst_n low forces every EX/MEM output to 0, FSM to IDLE, count to 0 and ExStall to 0, including mid-multiply.

Configuration
REQ-026 With EX_FORWARD_EN defined, REQ-017 applies; without it, operands come straight from IDIExreadData1/2 and the MemWB*/ExMem* feedback inputs are ignored.

Structure
REQ-027 A shared package holds the AluOp code constants and the MUL_LATENCY default.
REQ-028 The combinational ALU is the sub-module alu, excluding MUL; the multiply FSM stays in execute_stage.

Verification
REQ-029 ADD 7 + 0xFFFFFFFF, AluSrc=0 -> ExMemAluResult=6, ExMemZero=0 after one edge.
REQ-030 Back-to-back ADD writing r5, then SUB reading r5 (EX_FORWARD_EN) -> SUB uses the forwarded EX/MEM value, not the stale IDIExreadData1.
REQ-031 MUL 3*5, MUL_LATENCY=4 -> ExStall high 3 cycles, 15 in EX/MEM on the 4th edge, bubbles before it.
REQ-032 ExFlush asserted on the 2nd BUSY cycle -> FSM IDLE, bubble, ExStall low next cycle.
REQ-033 rst_n low during BUSY -> all outputs 0 immediately; the next op after release is single-cycle.
REQ-034 Forward target r0 with WriteRegEnable=1 -> no forwarding; SLT -1 < 1 -> result 1.
